// File: rtl/vga_sprite_engine_if.sv
// Board-facing signal bundle for the sprite engine: raw buttons in, VGA connector out.
interface vga_sprite_engine_if;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic       Hsync;
  logic       Vsync;
  logic [3:0] vgaRed;
  logic [3:0] vgaGreen;
  logic [3:0] vgaBlue;
  logic       de;
  logic       frame_start;

  modport master (
    input  btnU, btnD, btnL, btnR,
    output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, de, frame_start
  );

  modport slave (
    output btnU, btnD, btnL, btnR,
    input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, de, frame_start
  );
endinterface

// File: rtl/vga_sprite_engine.sv
// Programmable VGA timing generator with a button-driven rectangular sprite.
// Position updates only on the last clock of a frame so every frame is tear-free.
module vga_sprite_engine #(
  parameter int          H_ACTIVE   = 1920,
  parameter int          H_FP       = 88,
  parameter int          H_SYNC     = 44,
  parameter int          H_BP       = 148,
  parameter int          V_ACTIVE   = 1080,
  parameter int          V_FP       = 4,
  parameter int          V_SYNC     = 5,
  parameter int          V_BP       = 36,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int          BOX_W      = 64,
  parameter int          BOX_H      = 64,
  parameter int          STEP       = 4,
  parameter int          DEB_CYCLES = 1000000,
  parameter logic [11:0] BOX_RGB    = 12'hF00,
  parameter logic [11:0] BG_RGB     = 12'h00F
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_sprite_engine_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(DEB_CYCLES + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW:0]   H_ACT    = (HW+1)'(H_ACTIVE);
  localparam logic [VW:0]   V_ACT    = (VW+1)'(V_ACTIVE);
  localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW:0]   BOX_WX   = (HW+1)'(BOX_W);
  localparam logic [VW:0]   BOX_HY   = (VW+1)'(BOX_H);
  localparam logic [HW:0]   X_MAX    = (HW+1)'(H_ACTIVE - BOX_W);
  localparam logic [VW:0]   Y_MAX    = (VW+1)'(V_ACTIVE - BOX_H);
  localparam logic [HW:0]   X_STEP   = (HW+1)'(STEP);
  localparam logic [VW:0]   Y_STEP   = (VW+1)'(STEP);
  localparam logic [HW-1:0] X_INIT   = HW'((H_ACTIVE - BOX_W) / 2);
  localparam logic [VW-1:0] Y_INIT   = VW'((V_ACTIVE - BOX_H) / 2);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  // Saturating move: opposing or absent requests leave the position alone.
  function automatic logic [HW-1:0] stepX(input logic [HW-1:0] pos,
                                          input logic dec, input logic inc);
    logic [HW:0] p;
    p = {1'b0, pos};
    if (dec && !inc)      p = (p < X_STEP) ? '0 : p - X_STEP;
    else if (inc && !dec) p = (p + X_STEP > X_MAX) ? X_MAX : p + X_STEP;
    return p[HW-1:0];
  endfunction

  function automatic logic [VW-1:0] stepY(input logic [VW-1:0] pos,
                                          input logic dec, input logic inc);
    logic [VW:0] p;
    p = {1'b0, pos};
    if (dec && !inc)      p = (p < Y_STEP) ? '0 : p - Y_STEP;
    else if (inc && !dec) p = (p + Y_STEP > Y_MAX) ? Y_MAX : p + Y_STEP;
    return p[VW-1:0];
  endfunction

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [3:0]    btnRaw, btnMeta, btnSync, btnDeb;
  logic [DW-1:0] debCnt [4];
  logic          frameEnd;
  logic [HW:0]   hx;
  logic [VW:0]   vy;
  logic          visible, hit, inHs, inVs;
  logic [11:0]   pixRgb;

  assign btnRaw   = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};
  assign frameEnd = (hcnt == H_LAST) && (vcnt == V_LAST);

  // Stage p0: raster counters, button conditioning and frame-end position update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
      x    <= X_INIT;
      y    <= Y_INIT;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
      if (frameEnd) begin
        x <= stepX(x, btnDeb[1], btnDeb[0]);
        y <= stepY(y, btnDeb[3], btnDeb[2]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btnMeta <= '0;
      btnSync <= '0;
      btnDeb  <= '0;
      for (int i = 0; i < 4; i++) debCnt[i] <= '0;
    end else begin
      btnMeta <= btnRaw;
      btnSync <= btnMeta;
      for (int i = 0; i < 4; i++) begin
        if (btnSync[i] != btnDeb[i]) begin
          if (debCnt[i] == DEB_LAST) begin
            btnDeb[i] <= btnSync[i];
            debCnt[i] <= '0;
          end else begin
            debCnt[i] <= debCnt[i] + DW'(1);
          end
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    hx      = {1'b0, hcnt};
    vy      = {1'b0, vcnt};
    visible = (hx < H_ACT) && (vy < V_ACT);
    hit     = (hx >= {1'b0, x}) && (hx < {1'b0, x} + BOX_WX) &&
              (vy >= {1'b0, y}) && (vy < {1'b0, y} + BOX_HY);
    inHs    = (hx >= HS_BEG) && (hx < HS_END);
    inVs    = (vy >= VS_BEG) && (vy < VS_END);
    pixRgb  = visible ? (hit ? BOX_RGB : BG_RGB) : 12'h000;
  end

  // Stage p1: registered outputs, all aligned one clock behind the counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.Hsync       <= ~HS_POL;
      bus.Vsync       <= ~VS_POL;
      bus.vgaRed      <= '0;
      bus.vgaGreen    <= '0;
      bus.vgaBlue     <= '0;
      bus.de          <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.Hsync       <= inHs ? HS_POL : ~HS_POL;
      bus.Vsync       <= inVs ? VS_POL : ~VS_POL;
      bus.vgaRed      <= pixRgb[11:8];
      bus.vgaGreen    <= pixRgb[7:4];
      bus.vgaBlue     <= pixRgb[3:0];
      bus.de          <= visible;
      bus.frame_start <= (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a 24x12 raster with a 4x2 sprite.
module tb_vga_sprite_engine;

  localparam int HT = 24;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sprite_engine_if vif ();

  vga_sprite_engine #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .BOX_W(4), .BOX_H(2), .STEP(3), .DEB_CYCLES(4),
    .BOX_RGB(12'hF00), .BG_RGB(12'h00F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  typedef struct {
    logic [3:0] btn;  // {U,D,L,R} held during the frame
    int         ex;   // expected x in the following frame
    int         ey;
  } vec_t;

  int nChecks = 0;
  int nPass   = 0;
  int frameNo = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic setBtn(input logic [3:0] b);
    {vif.btnU, vif.btnD, vif.btnL, vif.btnR} = b;
  endtask

  // Called when the output for pixel (0,0) is on the pins; walks one whole frame.
  task automatic checkFrame(input int ex, input int ey, input logic [3:0] base,
                            input logic [3:0] pmask, input int pstart, input int plen);
    int pixErr = 0;
    int deErr  = 0;
    int hsErr  = 0;
    int vsErr  = 0;
    int fsErr  = 0;
    int mx     = -1;
    int my     = -1;
    for (int i = 0; i < FRAME; i++) begin
      int h, v;
      logic vis, hit, expHs, expVs;
      logic [11:0] expRgb, actRgb;
      h      = i % HT;
      v      = i / HT;
      vis    = (h < 16) && (v < 8);
      hit    = (h >= ex) && (h < ex + 4) && (v >= ey) && (v < ey + 2);
      expRgb = vis ? (hit ? 12'hF00 : 12'h00F) : 12'h000;
      expHs  = !((h >= 18) && (h < 21));
      expVs  = !((v >= 9) && (v < 11));
      actRgb = {vif.vgaRed, vif.vgaGreen, vif.vgaBlue};
      if (actRgb !== expRgb) pixErr++;
      if (vif.de !== vis) deErr++;
      if (vif.Hsync !== expHs) hsErr++;
      if (vif.Vsync !== expVs) vsErr++;
      if (vif.frame_start !== (i == 0)) fsErr++;
      if (mx < 0 && actRgb == 12'hF00) begin
        mx = h;
        my = v;
      end
      setBtn((i >= pstart && i < pstart + plen) ? pmask : base);
      @(posedge clk);
      #1;
    end
    check($sformatf("f%0d_pix_errors", frameNo), pixErr, 0);
    check($sformatf("f%0d_de_errors", frameNo), deErr, 0);
    check($sformatf("f%0d_hsync_errors", frameNo), hsErr, 0);
    check($sformatf("f%0d_vsync_errors", frameNo), vsErr, 0);
    check($sformatf("f%0d_fstart_errors", frameNo), fsErr, 0);
    check($sformatf("f%0d_box_x", frameNo), mx, ex);
    check($sformatf("f%0d_box_y", frameNo), my, ey);
    frameNo++;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_hsync"}, int'(vif.Hsync), 1);
    check({tag, "_vsync"}, int'(vif.Vsync), 1);
    check({tag, "_rgb"}, int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), 0);
    check({tag, "_de"}, int'(vif.de), 0);
    check({tag, "_fstart"}, int'(vif.frame_start), 0);
  endtask

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_U    = 4'b1000;
  localparam logic [3:0] B_D    = 4'b0100;
  localparam logic [3:0] B_L    = 4'b0010;
  localparam logic [3:0] B_R    = 4'b0001;

  initial begin
    vec_t vecs [17];
    int curX, curY;

    vecs[0]  = '{B_R,       9,  3};
    vecs[1]  = '{B_R,       12, 3};
    vecs[2]  = '{B_R,       12, 3};
    vecs[3]  = '{B_R,       12, 3};
    vecs[4]  = '{B_L,       9,  3};
    vecs[5]  = '{B_L,       6,  3};
    vecs[6]  = '{B_L,       3,  3};
    vecs[7]  = '{B_L,       0,  3};
    vecs[8]  = '{B_L,       0,  3};
    vecs[9]  = '{B_U | B_D, 0,  3};
    vecs[10] = '{B_L | B_R, 0,  3};
    vecs[11] = '{B_D,       0,  6};
    vecs[12] = '{B_D,       0,  6};
    vecs[13] = '{B_U | B_R, 3,  3};
    vecs[14] = '{B_U,       3,  0};
    vecs[15] = '{B_NONE,    3,  0};
    vecs[16] = '{B_NONE,    3,  0};

    setBtn(B_NONE);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");

    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("fstart_after_release", int'(vif.frame_start), 1);

    curX = 6;
    curY = 3;
    checkFrame(curX, curY, B_NONE, B_NONE, 0, 0);
    checkFrame(curX, curY, B_NONE, B_NONE, 0, 0);

    for (int k = 0; k < 17; k++) begin
      checkFrame(curX, curY, vecs[k].btn, B_NONE, 0, 0);
      curX = vecs[k].ex;
      curY = vecs[k].ey;
    end

    // Short glitch never reaches the debounce threshold.
    checkFrame(3, 0, B_NONE, B_R, 100, 3);
    // Press accepted just before the frame end gives exactly one step.
    checkFrame(3, 0, B_NONE, B_R, 280, 6);
    checkFrame(6, 0, B_NONE, B_NONE, 0, 0);
    checkFrame(6, 0, B_L, B_NONE, 0, 0);
    checkFrame(3, 0, B_L, B_NONE, 0, 0);

    // Sprite now at x=0; reset mid-line on line 5 with L still held.
    repeat (5 * HT + 7) @(posedge clk);
    #1;
    check("pre_reset_de", int'(vif.de), 1);
    #2 reset = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("held_reset");
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("fstart_after_midreset", int'(vif.frame_start), 1);
    checkFrame(6, 3, B_L, B_NONE, 0, 0);
    checkFrame(3, 3, B_NONE, B_NONE, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
